// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard control unit.
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    VWAIT = 1'b1
  } vmem_state_t;

  localparam int DEF_REG_ADDR_W = 4;
  localparam int DEF_VMEM_LAT   = 4;
  localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/hazard_control_unit_vmem_stall_fsm.sv
// Holds the M stage for VMEM_LAT cycles while a vector memory op is in flight.
module vmem_stall_fsm
  import hazard_pkg::*;
#(
  parameter int VMEM_LAT = DEF_VMEM_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic VecMemM,
  output logic vstall,
  output logic BusyVM
);

  localparam int CW = (VMEM_LAT > 2) ? $clog2(VMEM_LAT) : 1;

  if (VMEM_LAT < 2) begin : g_bad_lat
    $fatal(1, "vmem_stall_fsm: VMEM_LAT must be >= 2");
  end

  vmem_state_t   state;
  logic [CW-1:0] cnt;

  // State and remaining-wait counter; VecMemM is only looked at in RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (VecMemM) begin
            state <= VWAIT;
            cnt   <= CW'(VMEM_LAT - 2);
          end else begin
            state <= RUN;
            cnt   <= cnt;
          end
        end
        VWAIT: begin
          if (cnt != '0) begin
            state <= VWAIT;
            cnt   <= cnt - CW'(1);
          end else begin
            state <= RUN;
            cnt   <= cnt;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Stall/busy decode, forced low while the pipeline is being purged
  always_comb begin
    vstall = 1'b0;
    BusyVM = 1'b0;
    if (rst) begin
      vstall = 1'b0;
      BusyVM = 1'b0;
    end else begin
      case (state)
        RUN: begin
          vstall = VecMemM;
          BusyVM = VecMemM;
        end
        VWAIT: begin
          vstall = (cnt != '0);
          BusyVM = 1'b1;
        end
        default: begin
          vstall = 1'b0;
          BusyVM = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline stall/flush sequencer: branch flushes, load-use bubbles,
// vector-memory freezes and a saturating stall-cycle counter.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int VMEM_LAT   = DEF_VMEM_LAT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  BranchTakenE,
  input  logic                  MemtoRegE,
  input  logic                  RegWriteE,
  input  logic [REG_ADDR_W-1:0] WA3E,
  input  logic [REG_ADDR_W-1:0] RA1D,
  input  logic [REG_ADDR_W-1:0] RA2D,
  input  logic                  VecMemM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  BusyVM,
  output logic [CNT_W-1:0]      StallCycles
);

  logic vstall;
  logic ld_stall;

  vmem_stall_fsm #(
    .VMEM_LAT (VMEM_LAT)
  ) u_vmem_stall_fsm (
    .clk     (clk),
    .rst     (rst),
    .VecMemM (VecMemM),
    .vstall  (vstall),
    .BusyVM  (BusyVM)
  );

  assign ld_stall = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));

  // Output priority: reset purge, then vector freeze, then branch over load-use
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (vstall) begin
      // E is frozen, so any pending branch or load-use is re-evaluated later
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else begin
      StallF = ld_stall & ~BranchTakenE;
      StallD = ld_stall & ~BranchTakenE;
      FlushD = BranchTakenE;
      FlushE = BranchTakenE | ld_stall;
    end
  end

  // Saturating count of decode-stall cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCycles <= '0;
    end else if (StallD && (StallCycles != {CNT_W{1'b1}})) begin
      StallCycles <= StallCycles + CNT_W'(1);
    end else begin
      StallCycles <= StallCycles;
    end
  end

endmodule
